// File: rtl/plcp_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plcp_pkg
//  Brief    : Shared PLCP types and constants (receiver and transmitter).
//  Revision : 1.0  initial release
// ============================================================================
package plcp_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SIGNAL = 2'd1,
    DATA   = 2'd2
  } plcp_state_t;

  localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
  localparam int SIGNAL_BITS = 24;
  localparam int RATE_W      = 4;
  localparam int LENGTH_W    = 12;
  localparam int TAIL_BITS   = 6;
  localparam int SCR_WIDTH   = 7;
  localparam int SCR_TAP_HI  = 6;
  localparam int SCR_TAP_LO  = 3;

  // Field order matches transmission order: rate arrives first.
  typedef struct packed {
    logic [RATE_W-1:0]    rate;
    logic                 reserved;
    logic [LENGTH_W-1:0]  length;
    logic                 parity;
    logic [TAIL_BITS-1:0] tail;
  } plcp_signal_t;

  function automatic logic signal_parity(input plcp_signal_t s);
    return ^{s.rate, s.reserved, s.length};
  endfunction

endpackage
`default_nettype wire

// File: rtl/plcp_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : plcp_frame_receiver_if
//  Brief    : Serial line input and MAC-side output bundle of the receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface plcp_frame_receiver_if;
  import plcp_pkg::*;

  logic                InValid;
  logic                Input;
  logic [7:0]          DataOut;
  logic                DataValid;
  logic [RATE_W-1:0]   RateOut;
  logic [LENGTH_W-1:0] LengthOut;
  logic                HeaderValid;
  logic                HeaderError;
  logic                FrameDone;
  logic                Busy;

  modport master (
    output InValid, Input,
    input  DataOut, DataValid, RateOut, LengthOut,
           HeaderValid, HeaderError, FrameDone, Busy
  );

  modport slave (
    input  InValid, Input,
    output DataOut, DataValid, RateOut, LengthOut,
           HeaderValid, HeaderError, FrameDone, Busy
  );

endinterface
`default_nettype wire

// File: rtl/plcp_frame_receiver_descrambler.sv
`default_nettype none
// ============================================================================
//  Module   : plcp_descrambler
//  Brief    : Additive x^7+x^4+1 descrambler, one bit per enabled cycle.
//  Revision : 1.0  initial release
// ============================================================================
module plcp_descrambler
  import plcp_pkg::*;
#(
  parameter logic [SCR_WIDTH-1:0] RESET_SEED = 7'h5D
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [SCR_WIDTH-1:0] Seed,
  input  logic                 En,
  input  logic                 Input,
  output logic                 Output
);

  logic [SCR_WIDTH-1:0] r_state;
  logic                 w_fb;

  assign w_fb   = r_state[SCR_TAP_HI] ^ r_state[SCR_TAP_LO];
  assign Output = Input ^ w_fb;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= RESET_SEED;
    end else if (Load) begin
      r_state <= Seed;
    end else if (En) begin
      r_state <= {r_state[SCR_WIDTH-2:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/plcp_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : plcp_frame_receiver
//  Brief    : Serial 802.11a PLCP receiver: preamble lock, SIGNAL parse,
//             payload descramble to bytes. Define PLCP_SIGNAL_CHECK_EN to
//             enable full SIGNAL field validation.
//  Revision : 1.0  initial release
// ============================================================================
module plcp_frame_receiver
  import plcp_pkg::*;
#(
  parameter int                   PREAMBLE_BITS  = 96,
  parameter int                   MAX_LENGTH     = 4095,
  parameter logic [SCR_WIDTH-1:0] SCRAMBLER_SEED = 7'h5D
) (
  input  logic                  Clock,
  input  logic                  Reset,
  plcp_frame_receiver_if.slave  bus
);

  localparam int                  ALT_W     = $clog2(PREAMBLE_BITS + 1);
  localparam logic [LENGTH_W-1:0] c_max_len = LENGTH_W'(MAX_LENGTH);
`ifdef PLCP_SIGNAL_CHECK_EN
  localparam logic                c_check_en = 1'b1;
`else
  localparam logic                c_check_en = 1'b0;
`endif

  plcp_state_t          r_state;
  plcp_state_t          w_state_nxt;

  logic [ALT_W-1:0]     r_alt_cnt;
  logic [4:0]           r_bit_cnt;
  logic [SIGNAL_BITS-2:0] r_sig;
  logic [6:0]           r_byte_sh;
  logic [LENGTH_W-1:0]  r_byte_cnt;

  logic [7:0]           r_data_out;
  logic                 r_data_valid;
  logic [RATE_W-1:0]    r_rate;
  logic [LENGTH_W-1:0]  r_length;
  logic                 r_hdr_valid;
  logic                 r_hdr_err;
  logic                 r_frame_done;

  logic [ALT_W-1:0]     w_alt_inc;
  logic                 w_expect;
  logic                 w_match;
  logic                 w_lock;
  logic                 w_sig_last;
  plcp_signal_t         w_hdr;
  logic                 w_len_zero;
  logic                 w_len_err;
  logic                 w_fmt_err;
  logic                 w_err;
  logic                 w_byte_last;
  logic                 w_last_byte;
  logic                 w_descr_out;

  logic                 w_load;
  logic                 w_descr_en;
  logic                 w_hdr_valid;
  logic                 w_hdr_err;
  logic                 w_data_valid;
  logic                 w_frame_done;

  // Preamble starts with 1, so the expected bit follows the pattern phase.
  assign w_expect   = PREAMBLE_PATTERN[3'd7 - r_alt_cnt[2:0]];
  assign w_match    = (bus.Input == w_expect);
  assign w_alt_inc  = r_alt_cnt + ALT_W'(1);
  assign w_lock     = (r_state == HUNT) && bus.InValid && w_match &&
                      (w_alt_inc == ALT_W'(PREAMBLE_BITS)) && !bus.Input;

  assign w_sig_last = (r_state == SIGNAL) && bus.InValid &&
                      (r_bit_cnt == 5'(SIGNAL_BITS - 1));
  assign w_hdr      = plcp_signal_t'({r_sig, bus.Input});
  assign w_len_zero = (w_hdr.length == '0);
  assign w_len_err  = (w_hdr.length > c_max_len);
  assign w_fmt_err  = (signal_parity(w_hdr) != w_hdr.parity) | w_hdr.reserved |
                      (|w_hdr.tail) | ~w_hdr.rate[0];
  assign w_err      = w_len_err | (c_check_en & w_fmt_err);

  assign w_byte_last = (r_state == DATA) && bus.InValid && (r_bit_cnt[2:0] == 3'd7);
  assign w_last_byte = ((r_byte_cnt + LENGTH_W'(1)) == r_length);

  plcp_descrambler #(
    .RESET_SEED (SCRAMBLER_SEED)
  ) u_descrambler (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (w_load),
    .Seed   (SCRAMBLER_SEED),
    .En     (w_descr_en),
    .Input  (bus.Input),
    .Output (w_descr_out)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT: begin
        if (w_lock) begin
          w_state_nxt = SIGNAL;
        end
      end
      SIGNAL: begin
        if (w_sig_last) begin
          w_state_nxt = (w_err || w_len_zero) ? HUNT : DATA;
        end
      end
      DATA: begin
        if (w_byte_last && w_last_byte) begin
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_descr_en   = 1'b0;
    w_hdr_valid  = 1'b0;
    w_hdr_err    = 1'b0;
    w_data_valid = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      SIGNAL: begin
        w_hdr_valid  = w_sig_last & ~w_err;
        w_hdr_err    = w_sig_last &  w_err;
        w_load       = w_sig_last & ~w_err & ~w_len_zero;
        w_frame_done = w_sig_last & ~w_err &  w_len_zero;
      end
      DATA: begin
        w_descr_en   = bus.InValid;
        w_data_valid = w_byte_last;
        w_frame_done = w_byte_last & w_last_byte;
      end
      default: ;
    endcase
  end

  // Strobes are rewritten every clock so each lasts exactly one cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_alt_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sig        <= '0;
      r_byte_sh    <= '0;
      r_byte_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_rate       <= '0;
      r_length     <= '0;
      r_hdr_valid  <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_data_valid <= w_data_valid;
      r_hdr_valid  <= w_hdr_valid;
      r_hdr_err    <= w_hdr_err;
      r_frame_done <= w_frame_done;

      if (w_sig_last) begin
        r_rate   <= w_hdr.rate;
        r_length <= w_hdr.length;
      end

      if (bus.InValid) begin
        case (r_state)
          HUNT: begin
            r_bit_cnt <= '0;
            if (w_lock) begin
              r_alt_cnt <= '0;
            end else if (w_match) begin
              r_alt_cnt <= w_alt_inc;
            end else begin
              r_alt_cnt <= {{(ALT_W-1){1'b0}}, bus.Input};
            end
          end
          SIGNAL: begin
            r_sig      <= {r_sig[SIGNAL_BITS-3:0], bus.Input};
            r_bit_cnt  <= w_sig_last ? 5'd0 : r_bit_cnt + 5'd1;
            r_byte_cnt <= '0;
          end
          DATA: begin
            r_byte_sh <= {r_byte_sh[5:0], w_descr_out};
            r_bit_cnt <= w_byte_last ? 5'd0 : r_bit_cnt + 5'd1;
            if (w_byte_last) begin
              r_data_out <= {r_byte_sh, w_descr_out};
              r_byte_cnt <= r_byte_cnt + LENGTH_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.DataOut     = r_data_out;
  assign bus.DataValid   = r_data_valid;
  assign bus.RateOut     = r_rate;
  assign bus.LengthOut   = r_length;
  assign bus.HeaderValid = r_hdr_valid;
  assign bus.HeaderError = r_hdr_err;
  assign bus.FrameDone   = r_frame_done;
  assign bus.Busy        = (r_state != HUNT);

endmodule
`default_nettype wire
